ctrl_hazard_pipe: RTL and testbench

- Next-generation control block for the pipelined RV32I core.
- Decodes op/funct3/funct7 in the Decode stage and carries control through registered D->E->M->W stages.
- Resolves branches and jumps in Execute; generates load-use stalls, control flushes and operand-forwarding selects.
- Sits between the fetch/decode datapath and the register file / ALU / data memory; replaces the single-cycle control decoder.

---
 rtl/ctrl_hazard_pipe.sv | 275 +++++++++++++++++++++++++++
 tb/tb_ctrl_hazard_pipe.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_hazard_pipe.sv
// Pipelined RV32I control: decode, D/E/M/W control registers, branch resolution,
// load-use stall, flush and forwarding. Optional performance counters: CTRL_PERF_CNT_EN.
module ctrl_hazard_pipe #(
    parameter int REG_AW = 5,
    parameter int ALUC_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        op_d,
    input  logic [2:0]        funct3_d,
    input  logic              funct7_d,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              zero_e,
    output logic [2:0]        immsrc_d,
    output logic [ALUC_W-1:0] alucontrol_e,
    output logic              alusrc_e,
    output logic [1:0]        pcsrc_e,
    output logic [1:0]        forward_ae,
    output logic [1:0]        forward_be,
    output logic [2:0]        memwrite_m,
    output logic [1:0]        resultsrc_w,
    output logic              regwrite_w,
    output logic [REG_AW-1:0] rd_w,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              illegal_d
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  retire_cnt
`endif
);

    localparam logic [6:0] OP_LUI   = 7'd55;
    localparam logic [6:0] OP_R     = 7'd51;
    localparam logic [6:0] OP_I     = 7'd19;
    localparam logic [6:0] OP_BR    = 7'd99;
    localparam logic [6:0] OP_JALR  = 7'd103;
    localparam logic [6:0] OP_JAL   = 7'd111;
    localparam logic [6:0] OP_LOAD  = 7'd3;
    localparam logic [6:0] OP_STORE = 7'd35;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [ALUC_W-1:0] ALU_ADD = ALUC_W'(3'b000);
    localparam logic [ALUC_W-1:0] ALU_SUB = ALUC_W'(3'b010);
    localparam logic [ALUC_W-1:0] ALU_SLL = ALUC_W'(3'b001);
    localparam logic [ALUC_W-1:0] ALU_XOR = ALUC_W'(3'b100);
    localparam logic [ALUC_W-1:0] ALU_SRL = ALUC_W'(3'b101);
    localparam logic [ALUC_W-1:0] ALU_AND = ALUC_W'(3'b111);

    typedef struct packed {
        logic              regwrite;
        logic [1:0]        resultsrc;
        logic [2:0]        memwrite;
        logic              alusrc;
        logic [ALUC_W-1:0] alucontrol;
        logic              jal;
        logic              jalr;
        logic              beq;
        logic              bne;
    } ctrl_t;

    ctrl_t             dec;
    logic [2:0]        dec_imm;
    logic              dec_legal;
    logic              rs1_used;
    logic              rs2_used;

    ctrl_t             e_ctrl;
    logic [REG_AW-1:0] e_rs1, e_rs2, e_rd;
    logic              m_regwrite, w_regwrite;
    logic [1:0]        m_resultsrc, w_resultsrc;
    logic [2:0]        m_memwrite;
    logic [REG_AW-1:0] m_rd, w_rd;

    logic [1:0]        pcsrc, fwd_a, fwd_b;
    logic              load_use, flush, stall, flush_e;

    always_comb begin
        dec       = '0;
        dec_imm   = IMM_I;
        dec_legal = 1'b1;
        case (op_d)
            OP_LUI: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec_imm      = IMM_U;
            end
            OP_R: begin
                dec.regwrite = 1'b1;
                case (funct3_d)
                    3'b000:  dec.alucontrol = funct7_d ? ALU_SUB : ALU_ADD;
                    3'b001:  dec.alucontrol = ALU_SLL;
                    3'b100:  dec.alucontrol = ALU_XOR;
                    3'b101:  dec.alucontrol = ALU_SRL;
                    3'b111:  dec.alucontrol = ALU_AND;
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_I: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec_legal    = (funct3_d == 3'b000);
            end
            OP_BR: begin
                dec.alucontrol = ALU_SUB;
                dec_imm        = IMM_B;
                case (funct3_d)
                    3'b000:  dec.beq = 1'b1;
                    3'b001:  dec.bne = 1'b1;
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_JALR: begin
                dec.regwrite  = 1'b1;
                dec.alusrc    = 1'b1;
                dec.resultsrc = 2'b10;
                dec.jalr      = 1'b1;
            end
            OP_JAL: begin
                dec.regwrite  = 1'b1;
                dec.resultsrc = 2'b10;
                dec.jal       = 1'b1;
                dec_imm       = IMM_J;
            end
            OP_LOAD: begin
                dec.regwrite  = 1'b1;
                dec.alusrc    = 1'b1;
                dec.resultsrc = 2'b01;
                case (funct3_d)
                    3'b010:  dec.memwrite = 3'b000;
                    3'b000:  dec.memwrite = 3'b010;
                    3'b100:  dec.memwrite = 3'b110;
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_STORE: begin
                dec.alusrc = 1'b1;
                dec_imm    = IMM_S;
                case (funct3_d)
                    3'b010:  dec.memwrite = 3'b001;
                    3'b000:  dec.memwrite = 3'b011;
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Register-use flags follow the opcode alone, so malformed funct3 variants still stall.
    assign rs1_used = !((op_d == OP_LUI) || (op_d == OP_JAL));
    assign rs2_used = (op_d == OP_R) || (op_d == OP_STORE) || (op_d == OP_BR);

    always_comb begin
        pcsrc = 2'b00;
        if (e_ctrl.jalr)
            pcsrc = 2'b10;
        else if (e_ctrl.jal || (e_ctrl.beq && zero_e) || (e_ctrl.bne && !zero_e))
            pcsrc = 2'b01;
    end

    assign load_use = (e_ctrl.resultsrc == 2'b01) && (e_rd != '0) &&
                      ((rs1_used && (e_rd == rs1_d)) || (rs2_used && (e_rd == rs2_d)));
    assign flush    = (pcsrc != 2'b00);
    assign stall    = load_use && !flush;
    assign flush_e  = flush || load_use;

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (m_regwrite && (m_rd != '0) && (m_rd == e_rs1))
            fwd_a = 2'b10;
        else if (w_regwrite && (w_rd != '0) && (w_rd == e_rs1))
            fwd_a = 2'b01;
        if (m_regwrite && (m_rd != '0) && (m_rd == e_rs2))
            fwd_b = 2'b10;
        else if (w_regwrite && (w_rd != '0) && (w_rd == e_rs2))
            fwd_b = 2'b01;
    end

    // Bubbles clear the register fields too, so they can never trigger forwarding.
    always_ff @(posedge clk) begin
        if (rst || flush_e || !dec_legal) begin
            e_ctrl <= '0;
            e_rs1  <= '0;
            e_rs2  <= '0;
            e_rd   <= '0;
        end else begin
            e_ctrl <= dec;
            e_rs1  <= rs1_d;
            e_rs2  <= rs2_d;
            e_rd   <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_regwrite  <= 1'b0;
            m_resultsrc <= 2'b00;
            m_memwrite  <= 3'b000;
            m_rd        <= '0;
            w_regwrite  <= 1'b0;
            w_resultsrc <= 2'b00;
            w_rd        <= '0;
        end else begin
            m_regwrite  <= e_ctrl.regwrite;
            m_resultsrc <= e_ctrl.resultsrc;
            m_memwrite  <= e_ctrl.memwrite;
            m_rd        <= e_rd;
            w_regwrite  <= m_regwrite;
            w_resultsrc <= m_resultsrc;
            w_rd        <= m_rd;
        end
    end

    assign immsrc_d     = (rst || !dec_legal) ? 3'b000 : dec_imm;
    assign illegal_d    = !rst && !dec_legal;
    assign alucontrol_e = rst ? '0 : e_ctrl.alucontrol;
    assign alusrc_e     = !rst && e_ctrl.alusrc;
    assign pcsrc_e      = rst ? 2'b00 : pcsrc;
    assign forward_ae   = rst ? 2'b00 : fwd_a;
    assign forward_be   = rst ? 2'b00 : fwd_b;
    assign memwrite_m   = rst ? 3'b000 : m_memwrite;
    assign resultsrc_w  = rst ? 2'b00 : w_resultsrc;
    assign regwrite_w   = !rst && w_regwrite;
    assign rd_w         = rst ? '0 : w_rd;
    assign stall_f      = !rst && stall;
    assign stall_d      = !rst && stall;
    assign flush_d      = !rst && flush;

`ifdef CTRL_PERF_CNT_EN
    logic             e_valid, m_valid, w_valid;
    logic [CNT_W-1:0] stall_q, flush_q, retire_q;

    // Saturating event counters; a separate valid chain marks non-bubbles such as stores.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid  <= 1'b0;
            m_valid  <= 1'b0;
            w_valid  <= 1'b0;
            stall_q  <= '0;
            flush_q  <= '0;
            retire_q <= '0;
        end else begin
            e_valid <= dec_legal && !flush_e;
            m_valid <= e_valid;
            w_valid <= m_valid;
            if (stall && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
            if (flush && (flush_q != '1))
                flush_q <= flush_q + CNT_W'(1);
            if (w_valid && (retire_q != '1))
                retire_q <= retire_q + CNT_W'(1);
        end
    end

    assign stall_cnt  = rst ? '0 : stall_q;
    assign flush_cnt  = rst ? '0 : flush_q;
    assign retire_cnt = rst ? '0 : retire_q;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_ctrl_hazard_pipe.sv
// Scoreboard bench for ctrl_hazard_pipe: directed hazard sequences plus random
// instruction streams, checked against an instruction-level pipeline model.
module tb_ctrl_hazard_pipe;
    localparam int REG_AW = 5;
    localparam int ALUC_W = 3;
`ifdef CTRL_PERF_CNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    typedef enum {K_BUBBLE, K_ILL, K_LUI, K_ADD, K_SUB, K_SLL, K_XOR, K_SRL, K_AND,
                  K_ADDI, K_BEQ, K_BNE, K_JALR, K_JAL, K_LW, K_LB, K_LBU, K_SW, K_SB} kind_t;

    typedef struct {
        kind_t      kind;
        logic [4:0] rs1, rs2, rd;
    } instr_t;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [4:0] rs1, rs2, rd;
        logic       zero;
    } stim_t;

    typedef struct {
        logic [2:0]  immsrc;
        logic [2:0]  alu;
        logic        alusrc;
        logic [1:0]  pcsrc, fa, fb;
        logic [2:0]  mem;
        logic [1:0]  res;
        logic        rw;
        logic [4:0]  rdw;
        logic        stall, flush, ill;
        logic [15:0] sc, fc, rc;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [6:0]        op_d;
    logic [2:0]        funct3_d;
    logic              funct7_d;
    logic [REG_AW-1:0] rs1_d, rs2_d, rd_d;
    logic              zero_e;
    logic [2:0]        immsrc_d;
    logic [ALUC_W-1:0] alucontrol_e;
    logic              alusrc_e;
    logic [1:0]        pcsrc_e, forward_ae, forward_be;
    logic [2:0]        memwrite_m;
    logic [1:0]        resultsrc_w;
    logic              regwrite_w;
    logic [REG_AW-1:0] rd_w;
    logic              stall_f, stall_d, flush_d, illegal_d;
`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cnt, flush_cnt, retire_cnt;
`endif

    ctrl_hazard_pipe #(.REG_AW(REG_AW), .ALUC_W(ALUC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .op_d(op_d), .funct3_d(funct3_d), .funct7_d(funct7_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .zero_e(zero_e),
        .immsrc_d(immsrc_d), .alucontrol_e(alucontrol_e), .alusrc_e(alusrc_e),
        .pcsrc_e(pcsrc_e), .forward_ae(forward_ae), .forward_be(forward_be),
        .memwrite_m(memwrite_m), .resultsrc_w(resultsrc_w), .regwrite_w(regwrite_w),
        .rd_w(rd_w), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .illegal_d(illegal_d)
`ifdef CTRL_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     checks = 0;
    int     passed = 0;
    exp_t   expq[$];
    stim_t  stimq[$];
    instr_t me, mm, mw;
    int     cnt_s, cnt_f, cnt_r;

    function automatic kind_t classify(logic [6:0] op, logic [2:0] f3, logic f7);
        case (op)
            7'd55:  return K_LUI;
            7'd51: begin
                case (f3)
                    3'd0: return f7 ? K_SUB : K_ADD;
                    3'd1: return K_SLL;
                    3'd4: return K_XOR;
                    3'd5: return K_SRL;
                    3'd7: return K_AND;
                    default: return K_ILL;
                endcase
            end
            7'd19:  return (f3 == 3'd0) ? K_ADDI : K_ILL;
            7'd99:  return (f3 == 3'd0) ? K_BEQ : (f3 == 3'd1) ? K_BNE : K_ILL;
            7'd103: return K_JALR;
            7'd111: return K_JAL;
            7'd3:   return (f3 == 3'd2) ? K_LW : (f3 == 3'd0) ? K_LB : (f3 == 3'd4) ? K_LBU : K_ILL;
            7'd35:  return (f3 == 3'd2) ? K_SW : (f3 == 3'd0) ? K_SB : K_ILL;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(kind_t k);
        case (k)
            K_SUB, K_BEQ, K_BNE: return 3'b010;
            K_SLL: return 3'b001;
            K_XOR: return 3'b100;
            K_SRL: return 3'b101;
            K_AND: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] imm_of(kind_t k);
        case (k)
            K_LUI: return 3'b100;
            K_SW, K_SB: return 3'b001;
            K_BEQ, K_BNE: return 3'b010;
            K_JAL: return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic alusrc_of(kind_t k);
        return k inside {K_LUI, K_ADDI, K_JALR, K_LW, K_LB, K_LBU, K_SW, K_SB};
    endfunction

    function automatic logic rw_of(kind_t k);
        return k inside {K_LUI, K_ADD, K_SUB, K_SLL, K_XOR, K_SRL, K_AND, K_ADDI,
                         K_JALR, K_JAL, K_LW, K_LB, K_LBU};
    endfunction

    function automatic logic [1:0] res_of(kind_t k);
        if (k inside {K_LW, K_LB, K_LBU}) return 2'b01;
        if (k inside {K_JAL, K_JALR}) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [2:0] mem_of(kind_t k);
        case (k)
            K_LB:  return 3'b010;
            K_LBU: return 3'b110;
            K_SW:  return 3'b001;
            K_SB:  return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] fwd_of(logic [4:0] rs, instr_t m, instr_t w);
        if (rw_of(m.kind) && m.rd != 0 && m.rd == rs) return 2'b10;
        if (rw_of(w.kind) && w.rd != 0 && w.rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic stim_t mk(kind_t k, logic [4:0] a, logic [4:0] b, logic [4:0] d,
                                 logic z, logic r);
        stim_t s;
        s = '{rst: r, op: 7'd0, f3: 3'd0, f7: 1'b0, rs1: a, rs2: b, rd: d, zero: z};
        case (k)
            K_LUI:  s.op = 7'd55;
            K_ADD:  s.op = 7'd51;
            K_SUB:  begin s.op = 7'd51; s.f7 = 1'b1; end
            K_SLL:  begin s.op = 7'd51; s.f3 = 3'd1; end
            K_XOR:  begin s.op = 7'd51; s.f3 = 3'd4; end
            K_SRL:  begin s.op = 7'd51; s.f3 = 3'd5; end
            K_AND:  begin s.op = 7'd51; s.f3 = 3'd7; end
            K_ADDI: s.op = 7'd19;
            K_BEQ:  s.op = 7'd99;
            K_BNE:  begin s.op = 7'd99; s.f3 = 3'd1; end
            K_JALR: s.op = 7'd103;
            K_JAL:  s.op = 7'd111;
            K_LW:   begin s.op = 7'd3; s.f3 = 3'd2; end
            K_LB:   s.op = 7'd3;
            K_LBU:  begin s.op = 7'd3; s.f3 = 3'd4; end
            K_SW:   begin s.op = 7'd35; s.f3 = 3'd2; end
            K_SB:   s.op = 7'd35;
            default: s.op = 7'd0;
        endcase
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act === req) passed++;
        else $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    endtask

    // Drives one Decode slot, records the expected outputs and steps the model one clock.
    task automatic applyStimulus(input stim_t s, output logic stalled);
        kind_t      kd;
        exp_t       x;
        logic [1:0] pc;
        logic       lu, r1u, r2u;
        int         cmax;
        cmax = (1 << CNT_W) - 1;
        rst = s.rst; op_d = s.op; funct3_d = s.f3; funct7_d = s.f7;
        rs1_d = s.rs1; rs2_d = s.rs2; rd_d = s.rd; zero_e = s.zero;
        kd  = classify(s.op, s.f3, s.f7);
        r1u = !(s.op inside {7'd55, 7'd111});
        r2u = s.op inside {7'd51, 7'd35, 7'd99};
        pc = 2'b00;
        if (me.kind == K_JALR) pc = 2'b10;
        else if (me.kind == K_JAL || (me.kind == K_BEQ && s.zero) || (me.kind == K_BNE && !s.zero))
            pc = 2'b01;
        lu = (res_of(me.kind) == 2'b01) && me.rd != 0 &&
             ((r1u && me.rd == s.rs1) || (r2u && me.rd == s.rs2));
        x = '{default: '0};
        if (!s.rst) begin
            x.immsrc = imm_of(kd);
            x.ill    = (kd == K_ILL);
            x.alu    = alu_of(me.kind);
            x.alusrc = alusrc_of(me.kind);
            x.pcsrc  = pc;
            x.fa     = fwd_of(me.rs1, mm, mw);
            x.fb     = fwd_of(me.rs2, mm, mw);
            x.mem    = mem_of(mm.kind);
            x.res    = res_of(mw.kind);
            x.rw     = rw_of(mw.kind);
            x.rdw    = mw.rd;
            x.flush  = (pc != 2'b00);
            x.stall  = lu && !x.flush;
            x.sc     = 16'(cnt_s);
            x.fc     = 16'(cnt_f);
            x.rc     = 16'(cnt_r);
        end
        expq.push_back(x);
        if (s.rst) begin
            me = '{K_BUBBLE, 0, 0, 0}; mm = me; mw = me;
            cnt_s = 0; cnt_f = 0; cnt_r = 0;
        end else begin
            if (x.stall && cnt_s < cmax) cnt_s++;
            if (x.flush && cnt_f < cmax) cnt_f++;
            if (mw.kind != K_BUBBLE && cnt_r < cmax) cnt_r++;
            mw = mm;
            mm = me;
            if (x.flush || lu || kd == K_ILL) me = '{K_BUBBLE, 0, 0, 0};
            else me = '{kd, s.rs1, s.rs2, s.rd};
        end
        stalled = x.stall;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checkOutput("immsrc_d", 16'(immsrc_d), 16'(e.immsrc));
                checkOutput("illegal_d", 16'(illegal_d), 16'(e.ill));
                checkOutput("alucontrol_e", 16'(alucontrol_e), 16'(e.alu));
                checkOutput("alusrc_e", 16'(alusrc_e), 16'(e.alusrc));
                checkOutput("pcsrc_e", 16'(pcsrc_e), 16'(e.pcsrc));
                checkOutput("forward_ae", 16'(forward_ae), 16'(e.fa));
                checkOutput("forward_be", 16'(forward_be), 16'(e.fb));
                checkOutput("memwrite_m", 16'(memwrite_m), 16'(e.mem));
                checkOutput("resultsrc_w", 16'(resultsrc_w), 16'(e.res));
                checkOutput("regwrite_w", 16'(regwrite_w), 16'(e.rw));
                checkOutput("rd_w", 16'(rd_w), 16'(e.rdw));
                checkOutput("stall_f", 16'(stall_f), 16'(e.stall));
                checkOutput("stall_d", 16'(stall_d), 16'(e.stall));
                checkOutput("flush_d", 16'(flush_d), 16'(e.flush));
`ifdef CTRL_PERF_CNT_EN
                checkOutput("stall_cnt", 16'(stall_cnt), e.sc);
                checkOutput("flush_cnt", 16'(flush_cnt), e.fc);
                checkOutput("retire_cnt", 16'(retire_cnt), e.rc);
`endif
            end
        end
    end

    initial begin
        int   idx;
        int   cyc;
        logic st;
        me = '{K_BUBBLE, 0, 0, 0}; mm = me; mw = me;
        cnt_s = 0; cnt_f = 0; cnt_r = 0;
        rst = 1'b1; op_d = 7'd51; funct3_d = 3'd0; funct7_d = 1'b0;
        rs1_d = 5'd2; rs2_d = 5'd3; rd_d = 5'd1; zero_e = 1'b0;

        // The zero field applies to the instruction one slot earlier, now in Execute.
        for (int i = 0; i < 3; i++) stimq.push_back(mk(K_ADD, 2, 3, 1, 1, 1));
        stimq.push_back(mk(K_SUB, 2, 3, 1, 0, 0));
        stimq.push_back(mk(K_ADD, 1, 3, 2, 0, 0));
        stimq.push_back(mk(K_XOR, 1, 1, 4, 0, 0));
        stimq.push_back(mk(K_ADDI, 1, 0, 0, 0, 0));
        stimq.push_back(mk(K_ADD, 0, 0, 8, 0, 0));
        stimq.push_back(mk(K_LW, 1, 0, 5, 0, 0));
        stimq.push_back(mk(K_ADD, 5, 7, 6, 0, 0));
        stimq.push_back(mk(K_LW, 1, 0, 5, 0, 0));
        stimq.push_back(mk(K_LUI, 5, 5, 5, 0, 0));
        stimq.push_back(mk(K_BEQ, 1, 2, 0, 0, 0));
        stimq.push_back(mk(K_ADD, 3, 4, 9, 1, 0));
        stimq.push_back(mk(K_BNE, 1, 2, 0, 0, 0));
        stimq.push_back(mk(K_ADD, 3, 4, 9, 1, 0));
        stimq.push_back(mk(K_JALR, 1, 0, 10, 0, 0));
        stimq.push_back(mk(K_ADD, 10, 1, 11, 0, 0));
        stimq.push_back(mk(K_SW, 10, 11, 2, 0, 0));
        stimq.push_back(mk(K_ILL, 1, 1, 3, 0, 0));
        stimq.push_back(mk(K_LB, 1, 0, 12, 0, 0));
        stimq.push_back(mk(K_LBU, 12, 0, 13, 0, 0));
        stimq.push_back(mk(K_SB, 13, 12, 1, 0, 0));
        stimq.push_back(mk(K_JAL, 0, 0, 1, 0, 0));
        for (int i = 0; i < 5; i++) begin
            stimq.push_back(mk(K_LW, 1, 0, 7, 0, 0));
            stimq.push_back(mk(K_AND, 7, 7, 8, 0, 0));
        end
        for (int n = 0; n < 400; n++) begin
            kind_t k;
            stim_t s;
            k = kind_t'($urandom_range(1, 18));
            if ($urandom_range(0, 3) == 0) k = K_LW;
            s = mk(k, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 2));
            if (k == K_ILL) begin
                case ($urandom_range(0, 6))
                    0: begin s.op = 7'd0;   s.f3 = 3'd0; end
                    1: begin s.op = 7'd51;  s.f3 = 3'd2; end
                    2: begin s.op = 7'd19;  s.f3 = 3'd3; end
                    3: begin s.op = 7'd99;  s.f3 = 3'd5; end
                    4: begin s.op = 7'd3;   s.f3 = 3'd1; end
                    5: begin s.op = 7'd35;  s.f3 = 3'd4; end
                    default: begin s.op = 7'd127; s.f3 = 3'd0; end
                endcase
            end
            if (!(k inside {K_ADD, K_SUB})) s.f7 = 1'($urandom_range(0, 1));
            if (k inside {K_LUI, K_JAL}) s.f3 = 3'($urandom_range(0, 7));
            stimq.push_back(s);
        end

        idx = 0;
        cyc = 0;
        while (idx < stimq.size() && cyc < 5000) begin
            @(posedge clk);
            #1;
            applyStimulus(stimq[idx], st);
            if (!st) idx++;
            cyc++;
        end
        for (int k = 0; k < 10 && expq.size() > 0; k++) @(negedge clk);
        if (idx < stimq.size() || expq.size() != 0) begin
            checks++;
            $display("[TB] FAIL drain: consumed %0d of %0d slots, %0d expectations left",
                     idx, stimq.size(), expq.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
